axi_burst_sequencer: RTL

AXI_BURST_SEQUENCER -- requirements
Module: axi_burst_sequencer

---
 rtl/axi_burst_sequencer_if.sv | 31 +++
 rtl/axi_burst_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/axi_burst_sequencer_if.sv
// Command and beat signal bundle for axi_burst_sequencer.
// The slave modport is the sequencer side; the master modport is the command source / beat sink.
interface axi_burst_sequencer_if #(
   parameter int unsigned BITSIZE64 = 0
);
   localparam int unsigned BeW = (BITSIZE64 != 0) ? 8 : 16;

   logic           CMD_VALID;
   logic           CMD_READY;
   logic [11:0]    CMD_ADDR;
   logic [7:0]     CMD_LEN;
   logic [2:0]     CMD_SIZE;
   logic [1:0]     CMD_BURST;
   logic           BEAT_VALID;
   logic           BEAT_READY;
   logic [11:0]    BEAT_ADDR;
   logic [BeW-1:0] BEAT_BE;
   logic           BEAT_LAST;
   logic           BEAT_ERR;
   logic           BUSY;

   modport slave (
      input  CMD_VALID, CMD_ADDR, CMD_LEN, CMD_SIZE, CMD_BURST, BEAT_READY,
      output CMD_READY, BEAT_VALID, BEAT_ADDR, BEAT_BE, BEAT_LAST, BEAT_ERR, BUSY
   );

   modport master (
      output CMD_VALID, CMD_ADDR, CMD_LEN, CMD_SIZE, CMD_BURST, BEAT_READY,
      input  CMD_READY, BEAT_VALID, BEAT_ADDR, BEAT_BE, BEAT_LAST, BEAT_ERR, BUSY
   );
endinterface

// File: rtl/axi_burst_sequencer.sv
// Expands one AXI-style burst command (FIXED/INCR/WRAP) into per-beat addresses and byte enables.
// Illegal commands still emit LEN+1 flagged beats so downstream beat counts stay matched.
module axi_burst_sequencer #(
   parameter int unsigned BITSIZE64 = 0
) (
   input logic                   ACLK,
   input logic                   ARESETn,
   axi_burst_sequencer_if.slave  bus
);
   localparam int unsigned BeW      = (BITSIZE64 != 0) ? 8 : 16;
   localparam logic [2:0]  MaxSize  = (BITSIZE64 != 0) ? 3'd3 : 3'd4;
   localparam logic [11:0] LaneMask = 12'(BeW - 1);

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstWrap  = 2'b10;
   localparam logic [1:0] BurstRsvd  = 2'b11;

   typedef enum logic [1:0] {StIdle, StRun, StErr} state_e;

   state_e      state_q, state_d;
   logic [11:0] addr_q, addr_d;
   logic [11:0] start_q, start_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  len_q, len_d;
   logic [2:0]  size_q, size_d;
   logic [1:0]  burst_q, burst_d;
   logic        init_q;

   logic        cmd_ready, cmd_fire, beat_valid, beat_fire, cmd_illegal, wrap_len_ok;
   logic [11:0] beat_bytes, incr_addr, wrap_mask, wrap_addr, next_addr;
   logic [31:0] lane_ones, be_shift;
   logic [BeW-1:0] beat_be;

   assign cmd_ready  = (state_q == StIdle) && init_q;
   assign cmd_fire   = bus.CMD_VALID && cmd_ready;
   assign beat_valid = (state_q != StIdle);
   assign beat_fire  = beat_valid && bus.BEAT_READY;

   assign wrap_len_ok = (bus.CMD_LEN == 8'd1) || (bus.CMD_LEN == 8'd3) ||
                        (bus.CMD_LEN == 8'd7) || (bus.CMD_LEN == 8'd15);
   assign cmd_illegal = (bus.CMD_BURST == BurstRsvd) || (bus.CMD_SIZE > MaxSize) ||
                        ((bus.CMD_BURST == BurstWrap) && !wrap_len_ok);

   // Aligned increment; WRAP keeps the span base from the start address and the offset from
   // the increment, which folds back to the base exactly when the upper boundary is reached.
   assign beat_bytes = 12'd1 << size_q;
   assign incr_addr  = (addr_q & ~(beat_bytes - 12'd1)) + beat_bytes;
   assign wrap_mask  = ((12'(len_q) + 12'd1) << size_q) - 12'd1;
   assign wrap_addr  = (start_q & ~wrap_mask) | (incr_addr & wrap_mask);

   always_comb begin
      next_addr = incr_addr;
      if (burst_q == BurstFixed) begin
         next_addr = addr_q;
      end else if (burst_q == BurstWrap) begin
         next_addr = wrap_addr;
      end
   end

   assign lane_ones = (32'd1 << (32'd1 << size_q)) - 32'd1;
   assign be_shift  = lane_ones << (addr_q & LaneMask);

   always_comb begin
      beat_be = '0;
      if (state_q == StRun) begin
         beat_be = (size_q == MaxSize) ? '1 : be_shift[BeW-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      start_d = start_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_fire) begin
               state_d = cmd_illegal ? StErr : StRun;
               addr_d  = bus.CMD_ADDR;
               start_d = bus.CMD_ADDR;
               cnt_d   = bus.CMD_LEN;
               len_d   = bus.CMD_LEN;
               size_d  = bus.CMD_SIZE;
               burst_d = bus.CMD_BURST;
            end
         end
         StRun, StErr: begin
            if (beat_fire) begin
               if (cnt_q == 8'd0) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q - 8'd1;
                  if (state_q == StRun) begin
                     addr_d = next_addr;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= StIdle;
         addr_q  <= '0;
         start_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         init_q  <= 1'b1;
      end
   end

   assign bus.CMD_READY  = cmd_ready;
   assign bus.BEAT_VALID = beat_valid;
   assign bus.BEAT_ADDR  = addr_q;
   assign bus.BEAT_BE    = beat_be;
   assign bus.BEAT_LAST  = beat_valid && (cnt_q == 8'd0);
   assign bus.BEAT_ERR   = (state_q == StErr);
   assign bus.BUSY       = beat_valid;
endmodule
